// File: rtl/pool_window_gen_pkg.sv
// Shared CNN defines: default lane count / pixel width and the 2x2 window word order.
// Word order within a lane's window is TL, TR, BL, BR from the lowest word upward.
package pool_window_gen_pkg;

  localparam int CNN_M_CO   = 4;
  localparam int CNN_M_CI   = 2;
  localparam int CNN_LANES  = CNN_M_CO * CNN_M_CI;
  localparam int CNN_MAX_BW = 8;

  localparam int WIN_TL    = 0;
  localparam int WIN_TR    = 1;
  localparam int WIN_BL    = 2;
  localparam int WIN_BR    = 3;
  localparam int WIN_WORDS = 4;

  // Word index of window position pos for a given lane in the packed window bus.
  function automatic int win_word(input int lane, input int pos);
    return lane * WIN_WORDS + pos;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-row line buffer for the pooling window generator: one write port,
// two asynchronous read ports (left and right column of a window).
module pool_line_buf #(
  parameter int DEPTH = 24,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_a_i,
  output logic [WIDTH-1:0] rd_data_a_o,
  input  logic [AW-1:0]    rd_addr_b_i,
  output logic [WIDTH-1:0] rd_data_b_o
);

  // Contents are don't-care until the even row rewrites them, so no reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = mem[rd_addr_a_i];
  assign rd_data_b_o = mem[rd_addr_b_i];

endmodule

// File: rtl/pool_window_gen.sv
// Builds 2x2 pooling windows from a raster pixel stream, one window per odd row/odd col pixel.
// Optional macro POOL_WIN_RELU_EN clamps negative (MSB set) pixels to zero on entry.
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int LANES  = CNN_LANES,
  parameter int MAX_BW = CNN_MAX_BW,
  parameter int FMAP_W = 24,
  parameter int FMAP_H = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic                      i_pix_valid,
  input  logic [LANES*MAX_BW-1:0]   i_pix,
  output logic                      o_win_valid,
  output logic [LANES*4*MAX_BW-1:0] o_win_fmap,
  output logic                      o_frame_done,
  output logic                      o_busy
);

  localparam int COL_W = $clog2(FMAP_W);
  localparam int ROW_W = $clog2(FMAP_H);
  localparam int PIX_W = LANES * MAX_BW;
  localparam int WIN_W = LANES * WIN_WORDS * MAX_BW;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVEN = 2'd1;
  localparam logic [1:0] ST_ODD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] bl_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_valid_q;
  logic             frame_done_q;

  logic [PIX_W-1:0] pix_in;
  logic [PIX_W-1:0] top_left;
  logic [PIX_W-1:0] top_right;
  logic             accept;
  logic             fire;
  logic             last_pix;

  // A coincident start wins over the pixel, which is dropped.
  assign accept   = i_pix_valid && !i_start && (state_q == ST_EVEN || state_q == ST_ODD);
  assign fire     = accept && (state_q == ST_ODD) && col_q[0];
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [MAX_BW-1:0] raw;
    assign raw = i_pix[gi*MAX_BW +: MAX_BW];
`ifdef POOL_WIN_RELU_EN
    assign pix_in[gi*MAX_BW +: MAX_BW] = raw[MAX_BW-1] ? '0 : raw;
`else
    assign pix_in[gi*MAX_BW +: MAX_BW] = raw;
`endif
    assign win_d[win_word(gi, WIN_TL)*MAX_BW +: MAX_BW] = top_left[gi*MAX_BW +: MAX_BW];
    assign win_d[win_word(gi, WIN_TR)*MAX_BW +: MAX_BW] = top_right[gi*MAX_BW +: MAX_BW];
    assign win_d[win_word(gi, WIN_BL)*MAX_BW +: MAX_BW] = bl_q[gi*MAX_BW +: MAX_BW];
    assign win_d[win_word(gi, WIN_BR)*MAX_BW +: MAX_BW] = pix_in[gi*MAX_BW +: MAX_BW];
  end

  // At an odd column, col-1 is col with the LSB cleared.
  pool_line_buf #(
    .DEPTH (FMAP_W),
    .WIDTH (PIX_W)
  ) u_line_buf (
    .clk         (clk),
    .wr_en_i     (accept && (state_q == ST_EVEN)),
    .wr_addr_i   (col_q),
    .wr_data_i   (pix_in),
    .rd_addr_a_i ({col_q[COL_W-1:1], 1'b0}),
    .rd_data_a_o (top_left),
    .rd_addr_b_i (col_q),
    .rd_data_b_o (top_right)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (i_start) begin
      state_d = ST_EVEN;
      col_d   = '0;
      row_d   = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = (state_q == ST_EVEN) ? ST_ODD : ST_EVEN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      bl_q         <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= fire;
      frame_done_q <= fire && last_pix;
      if (accept && (state_q == ST_ODD) && !col_q[0]) begin
        bl_q <= pix_in;
      end
      if (fire) begin
        win_q <= win_d;
      end
    end
  end

  assign o_win_valid  = win_valid_q;
  assign o_win_fmap   = win_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
